// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - SAP sequencer opcodes, control-word bit map and widths
package sap_pkg;

    localparam int CW_W = 12;
    localparam int T_W  = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int PC_INC  = 11;
    localparam int PC_OUT  = 10;
    localparam int MAR_LD  = 9;
    localparam int RAM_OUT = 8;
    localparam int IR_LD   = 7;
    localparam int IR_OUT  = 6;
    localparam int A_LD    = 5;
    localparam int A_OUT   = 4;
    localparam int ALU_SUB = 3;
    localparam int ALU_OUT = 2;
    localparam int B_LD    = 1;
    localparam int OUT_LD  = 0;

    function automatic logic is_onehot(input logic [T_W-1:0] v);
        return (v != '0) && ((v & (v - T_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/t_state_ring.sv
// rtl/t_state_ring.sv - one-hot T-state ring with hold, early return and recovery
module t_state_ring
    import sap_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    input  logic           early_end,
    output logic [T_W-1:0] t_state
);

    logic [T_W-1:0] r_t_state;

    // Recovery outranks hold so a corrupted ring cannot stay frozen while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t_state <= T_W'(1);
        end else if (!is_onehot(r_t_state)) begin
            r_t_state <= T_W'(1);
        end else if (hold) begin
            r_t_state <= r_t_state;
        end else if (early_end) begin
            r_t_state <= T_W'(1);
        end else begin
            r_t_state <= {r_t_state[T_W-2:0], r_t_state[T_W-1]};
        end
    end

    assign t_state = r_t_state;

endmodule

// File: rtl/sap_controller_sequencer.sv
// rtl/sap_controller_sequencer.sv - SAP T-state sequencer and microcode decoder (option: SAP_EARLY_END_EN)
module sap_controller_sequencer
    import sap_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      opcode,
    output logic [T_W-1:0]  t_state,
    output logic [CW_W-1:0] ctrl,
    output logic            halt
);

    logic            r_halt;
    logic [T_W-1:0]  w_t;
    logic [CW_W-1:0] w_ctrl;
    logic            w_is_hlt;
    logic            w_hold;
    logic            w_early_end;

    assign w_is_hlt = (opcode == OP_HLT);
    assign w_hold   = r_halt | (w_t[3] & w_is_hlt);

`ifdef SAP_EARLY_END_EN
    logic w_known;
    assign w_known     = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                         (opcode == OP_OUT) || (opcode == OP_HLT);
    assign w_early_end = (w_t[4] & (opcode == OP_LDA)) |
                         (w_t[3] & ((opcode == OP_OUT) | !w_known));
`else
    assign w_early_end = 1'b0;
`endif

    t_state_ring u_ring (
        .clk       (clk),
        .rst       (rst),
        .hold      (w_hold),
        .early_end (w_early_end),
        .t_state   (w_t)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else if (w_t[3] && w_is_hlt) begin
            r_halt <= 1'b1;
        end
    end

    // Opcode is only consulted from T4 on; fetch words are opcode-independent.
    always_comb begin
        w_ctrl = '0;
        if (w_t[0]) begin
            w_ctrl[PC_OUT] = 1'b1;
            w_ctrl[MAR_LD] = 1'b1;
        end else if (w_t[1]) begin
            w_ctrl[PC_INC] = 1'b1;
        end else if (w_t[2]) begin
            w_ctrl[RAM_OUT] = 1'b1;
            w_ctrl[IR_LD]   = 1'b1;
        end else if (w_t[3]) begin
            if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                w_ctrl[IR_OUT] = 1'b1;
                w_ctrl[MAR_LD] = 1'b1;
            end else if (opcode == OP_OUT) begin
                w_ctrl[A_OUT]  = 1'b1;
                w_ctrl[OUT_LD] = 1'b1;
            end
        end else if (w_t[4]) begin
            if (opcode == OP_LDA) begin
                w_ctrl[RAM_OUT] = 1'b1;
                w_ctrl[A_LD]    = 1'b1;
            end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                w_ctrl[RAM_OUT] = 1'b1;
                w_ctrl[B_LD]    = 1'b1;
            end
        end else if (w_t[5]) begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
                w_ctrl[ALU_OUT] = 1'b1;
                w_ctrl[A_LD]    = 1'b1;
                w_ctrl[ALU_SUB] = (opcode == OP_SUB);
            end
        end
        if (r_halt) begin
            w_ctrl = '0;
        end
    end

    assign t_state = w_t;
    assign ctrl    = w_ctrl;
    assign halt    = r_halt;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// tb/tb_sap_controller_sequencer.sv - scoreboard bench for sap_controller_sequencer (option: SAP_EARLY_END_EN)
module tb_sap_controller_sequencer;

    typedef struct {
        logic [5:0]  t;
        logic [11:0] c;
        logic        h;
    } exp_t;

`ifdef SAP_EARLY_END_EN
    localparam int N_LDA = 5;
    localparam int N_SHORT = 4;
`else
    localparam int N_LDA = 6;
    localparam int N_SHORT = 6;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [5:0]  t_state;
    logic [11:0] ctrl;
    logic        halt;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    sap_controller_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .t_state (t_state),
        .ctrl    (ctrl),
        .halt    (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 3;
            if (t_state !== e.t) begin
                errors = errors + 1;
                $display("FAIL t_state at %0t: got %b want %b", $time, t_state, e.t);
            end
            if (ctrl !== e.c) begin
                errors = errors + 1;
                $display("FAIL ctrl at %0t (t=%b): got %h want %h", $time, t_state, ctrl, e.c);
            end
            if (halt !== e.h) begin
                errors = errors + 1;
                $display("FAIL halt at %0t: got %b want %b", $time, halt, e.h);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] op, input logic [5:0] et,
                        input logic [11:0] ec, input logic eh);
        exp_t e;
        rst    = r;
        opcode = op;
        e.t = et;
        e.c = ec;
        e.h = eh;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] op, input int n, input logic [11:0] c4,
                       input logic [11:0] c5, input logic [11:0] c6);
        step(1'b0, op ^ 4'h5, 6'b000001, 12'h600, 1'b0);
        step(1'b0, ~op,       6'b000010, 12'h800, 1'b0);
        step(1'b0, op ^ 4'hA, 6'b000100, 12'h180, 1'b0);
        step(1'b0, op,        6'b001000, c4,      1'b0);
        if (n >= 5) step(1'b0, op, 6'b010000, c5, 1'b0);
        if (n == 6) step(1'b0, op, 6'b100000, c6, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        opcode = 4'h0;
        @(posedge clk);
        #1;
        step(1'b1, 4'h0, 6'b000001, 12'h600, 1'b0);

        run(4'h1, 6, 12'h240, 12'h102, 12'h024);
        run(4'h2, 6, 12'h240, 12'h102, 12'h02C);
        run(4'h0, N_LDA, 12'h240, 12'h120, 12'h000);
        run(4'hE, N_SHORT, 12'h011, 12'h000, 12'h000);
        run(4'h7, N_SHORT, 12'h000, 12'h000, 12'h000);

        step(1'b0, 4'h3, 6'b000001, 12'h600, 1'b0);
        step(1'b0, 4'h1, 6'b000010, 12'h800, 1'b0);
        step(1'b0, 4'h0, 6'b000100, 12'h180, 1'b0);
        step(1'b0, 4'hF, 6'b001000, 12'h000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0) ? 4'h1 : 4'hE, 6'b001000, 12'h000, 1'b1);
        end
        step(1'b1, 4'h1, 6'b001000, 12'h000, 1'b1);

        step(1'b0, 4'h1, 6'b000001, 12'h600, 1'b0);
        step(1'b0, 4'h1, 6'b000010, 12'h800, 1'b0);
        step(1'b0, 4'h1, 6'b000100, 12'h180, 1'b0);
        step(1'b0, 4'h1, 6'b001000, 12'h240, 1'b0);
        step(1'b1, 4'h1, 6'b010000, 12'h102, 1'b0);

        run(4'h1, 6, 12'h240, 12'h102, 12'h024);
        step(1'b0, 4'h0, 6'b000001, 12'h600, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
